uart_digit_rx: RTL and testbench

Serial receiver that consumes the ASCII digit stream produced by the four-digit UART transmit path and rebuilds the four display digits. It oversamples an asynchronous 8N1 line, validates framing, and filters for ASCII '0'–'9'. Accepted digits are written into a four-slot digit register, in transmit order, that feeds a seven-segment display on the receiving board. It is the loopback/far-end counterpart of the transmit chain.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_digit_rx.sv | 194 +++++++++++++++++++
 tb/tb_uart_digit_rx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, ASCII constants and the
// oversampling divisor helper used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    // Clock cycles per oversample tick, truncated.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_hz / (baud * oversample);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 0..DIV-1 counter producing a one-cycle tick at DIV-1.
// Held at zero while disabled so every enabled run starts phase-aligned.
module uart_baud_tick #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_digit_rx.sv
// 8N1 oversampling receiver that keeps ASCII '0'-'9' bytes in a four-slot
// digit register for the far-end seven-segment display.
module uart_digit_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       clear,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       framing_err,
    output logic       non_digit,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       frame_done
);

    localparam int unsigned DIV    = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
    localparam logic [TCNT_W-1:0] MID_TICK = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] BIT_TICK = TCNT_W'(OVERSAMPLE - 1);

    // Synchronizer resets to the idle line level so reset release is not a start edge.
    logic [1:0] sync_q;
    logic       rxd_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxd_s = sync_q[1];

    uart_state_e       state_q;
    logic [TCNT_W-1:0] tcnt_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic [7:0]        byte_data_q;
    logic              byte_valid_q;
    logic              framing_err_q;
    logic              tick;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != IDLE),
        .tick_o (tick)
    );

    // NOTE: every register below is assigned with <= so all state advances
    // together on the edge; blocking here would let later lines see new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tcnt_q        <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_data_q   <= '0;
            byte_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            byte_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tcnt_q <= '0;
                    if (!rxd_s) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tcnt_q == MID_TICK) begin
                            tcnt_q    <= '0;
                            bit_idx_q <= '0;
                            state_q   <= rxd_s ? IDLE : DATA;
                        end else begin
                            tcnt_q <= tcnt_q + TCNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tcnt_q == BIT_TICK) begin
                            tcnt_q  <= '0;
                            shift_q <= {rxd_s, shift_q[7:1]};
                            if (bit_idx_q == 3'd7) begin
                                state_q <= STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + TCNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tcnt_q == BIT_TICK) begin
                            tcnt_q <= '0;
                            if (rxd_s) begin
                                byte_data_q  <= shift_q;
                                byte_valid_q <= 1'b1;
                                state_q      <= IDLE;
                            end else begin
                                framing_err_q <= 1'b1;
                                state_q       <= BREAK;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + TCNT_W'(1);
                        end
                    end
                end
                BREAK: begin
                    tcnt_q <= '0;
                    if (rxd_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tcnt_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic [3:0][3:0] digits_q, digits_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic            frame_done_q, frame_done_d;
    logic            non_digit_q, non_digit_d;

    // NOTE: every output of this block gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        digits_d     = digits_q;
        wr_ptr_d     = wr_ptr_q;
        frame_done_d = 1'b0;
        non_digit_d  = 1'b0;
        if (clear) begin
            digits_d = '0;
            wr_ptr_d = '0;
        end else if (byte_valid_q) begin
            if (is_digit(byte_data_q)) begin
                digits_d[wr_ptr_q] = byte_data_q[3:0];
                wr_ptr_d           = wr_ptr_q + 2'd1;
                frame_done_d       = (wr_ptr_q == 2'd3);
            end else if (byte_data_q == ASCII_CR) begin
                wr_ptr_d = '0;
            end else begin
                non_digit_d = 1'b1;
            end
        end
    end

    // NOTE: the digit register is reset explicitly so the display comes up
    // blank; it is flop storage, not a RAM, so the reset costs nothing odd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q     <= '0;
            wr_ptr_q     <= '0;
            frame_done_q <= 1'b0;
            non_digit_q  <= 1'b0;
        end else begin
            digits_q     <= digits_d;
            wr_ptr_q     <= wr_ptr_d;
            frame_done_q <= frame_done_d;
            non_digit_q  <= non_digit_d;
        end
    end

    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign framing_err = framing_err_q;
    assign non_digit   = non_digit_q;
    assign frame_done  = frame_done_q;
    assign digit0      = digits_q[0];
    assign digit1      = digits_q[1];
    assign digit2      = digits_q[2];
    assign digit3      = digits_q[3];

endmodule

// File: tb/tb_uart_digit_rx.sv
// Bench for uart_digit_rx: directed scenarios plus random frames, checked every
// cycle against a frame-level model of the receiver and digit register.
module tb_uart_digit_rx;

    localparam int DIV         = 10;
    localparam int OS          = 16;
    localparam int BIT_CYC     = DIV * OS;
    localparam int FRAME_CYC   = 10 * BIT_CYC;
    // Drive edge -> 2 sync flops -> START entry, then mid stop bit.
    localparam int STOP_SAMPLE = 3 + DIV * (OS / 2 + 9 * OS);

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       clear;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       framing_err;
    logic       non_digit;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       frame_done;

    uart_digit_rx #(
        .CLK_HZ     (1_600_000),
        .BAUD       (10_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .clear       (clear),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .framing_err (framing_err),
        .non_digit   (non_digit),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        bit         ok;
        logic [7:0] data;
    } ev_t;
    ev_t evq[$];

    int         m_dig[4];
    int         m_ptr;
    logic [7:0] m_byte;
    bit         m_bv, m_fe, m_fd, m_nd;

    int n_cmp = 0;
    int n_bad = 0;
    int bv_cnt = 0, fe_cnt = 0, nd_cnt = 0, fd_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        foreach (m_dig[i]) m_dig[i] = 0;
        m_ptr  = 0;
        m_byte = 8'h00;
        m_bv   = 1'b0;
        m_fe   = 1'b0;
        m_fd   = 1'b0;
        m_nd   = 1'b0;
        evq.delete();
    endtask

    // Advance the model from this cycle to the next one.
    task automatic step_model();
        bit  nfd = 1'b0;
        bit  nnd = 1'b0;
        ev_t ev;
        if (clear) begin
            foreach (m_dig[i]) m_dig[i] = 0;
            m_ptr = 0;
        end else if (m_bv) begin
            if (m_byte >= 8'h30 && m_byte <= 8'h39) begin
                m_dig[m_ptr] = int'(m_byte) - 'h30;
                nfd   = (m_ptr == 3);
                m_ptr = (m_ptr + 1) % 4;
            end else if (m_byte == 8'h0D) begin
                m_ptr = 0;
            end else begin
                nnd = 1'b1;
            end
        end
        m_fd = nfd;
        m_nd = nnd;
        m_bv = 1'b0;
        m_fe = 1'b0;
        if (evq.size() > 0 && evq[0].at == cyc + 1) begin
            ev = evq.pop_front();
            if (ev.ok) begin
                m_bv   = 1'b1;
                m_byte = ev.data;
            end else begin
                m_fe = 1'b1;
            end
        end
    endtask

    initial begin
        int d_act[4];
        reset_model();
        forever begin
            @(negedge clk);
            #1;
            if (rst) reset_model();
            d_act = '{int'(digit0), int'(digit1), int'(digit2), int'(digit3)};
            check("byte_valid",  int'(byte_valid),  int'(m_bv));
            check("framing_err", int'(framing_err), int'(m_fe));
            check("non_digit",   int'(non_digit),   int'(m_nd));
            check("frame_done",  int'(frame_done),  int'(m_fd));
            check("byte_data",   int'(byte_data),   int'(m_byte));
            foreach (d_act[i]) check($sformatf("digit%0d", i), d_act[i], m_dig[i]);
            if (!rst) begin
                bv_cnt += int'(byte_valid);
                fe_cnt += int'(framing_err);
                nd_cnt += int'(non_digit);
                fd_cnt += int'(frame_done);
                step_model();
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the stop bit.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok,
                              input int clear_at, input int abort_at);
        logic [9:0] bits;
        ev_t        ev;
        bits = {stop_ok, data, 1'b0};
        ev.at   = cyc + STOP_SAMPLE;
        ev.ok   = stop_ok;
        ev.data = data;
        evq.push_back(ev);
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (i == abort_at) begin
                rst   = 1'b1;
                rxd   = 1'b1;
                clear = 1'b0;
                repeat (10) @(negedge clk);
                rst = 1'b0;
                return;
            end
            rxd   = bits[i / BIT_CYC];
            clear = (i == clear_at);
            @(negedge clk);
        end
        clear = 1'b0;
    endtask

    task automatic send_char(input logic [7:0] data);
        send_frame(data, 1'b1, -1, -1);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, f0, n0, d0;
        logic [7:0] rb;
        bit  ok;
        int  r, gap;

        rst   = 1'b1;
        rxd   = 1'b1;
        clear = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle(20);
        check("reset_byte_data", int'(byte_data), 0);
        check("reset_digit0",    int'(digit0),    0);

        // "1234" back to back
        b0 = bv_cnt; d0 = fd_cnt;
        send_char("1"); send_char("2"); send_char("3"); send_char("4");
        idle(10);
        check("seq_digit0", int'(digit0), 1);
        check("seq_digit1", int'(digit1), 2);
        check("seq_digit2", int'(digit2), 3);
        check("seq_digit3", int'(digit3), 4);
        check("seq_valid_count", bv_cnt - b0, 4);
        check("seq_frame_done_count", fd_cnt - d0, 1);

        // clear, then "7", CR, "9"
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n0 = nd_cnt;
        send_char("7"); send_char(8'h0D); send_char("9");
        idle(10);
        check("cr_digit0", int'(digit0), 9);
        check("cr_digit1", int'(digit1), 0);
        check("cr_digit3", int'(digit3), 0);
        check("cr_non_digit_count", nd_cnt - n0, 0);

        // non-digit byte
        send_char(8'h41);
        idle(10);
        check("alpha_byte_data", int'(byte_data), 'h41);
        check("alpha_non_digit_count", nd_cnt - n0, 1);
        check("alpha_digit0", int'(digit0), 9);

        // framing error followed by a long break, then a good "5"
        b0 = bv_cnt; f0 = fe_cnt;
        send_frame(8'h35, 1'b0, -1, -1);
        rxd = 1'b0;
        repeat (500) @(negedge clk);
        idle(20);
        check("ferr_count", fe_cnt - f0, 1);
        check("ferr_valid_count", bv_cnt - b0, 0);
        check("ferr_digit1", int'(digit1), 0);
        send_char("5");
        idle(10);
        check("after_ferr_digit1", int'(digit1), 5);

        // short glitch while idle
        b0 = bv_cnt; f0 = fe_cnt;
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        idle(300);
        check("glitch_valid_count", bv_cnt - b0, 0);
        check("glitch_ferr_count", fe_cnt - f0, 0);

        // reset during data bit 4 of "8", then "6"
        b0 = bv_cnt;
        send_frame("8", 1'b1, -1, 5 * BIT_CYC + BIT_CYC / 2);
        idle(50);
        send_char("6");
        idle(10);
        check("rst_digit0", int'(digit0), 6);
        check("rst_digit1", int'(digit1), 0);
        check("rst_valid_count", bv_cnt - b0, 1);

        // clear coincident with byte_valid of "3"
        send_frame("3", 1'b1, STOP_SAMPLE, -1);
        idle(10);
        check("clr_digit0", int'(digit0), 0);
        check("clr_byte_data", int'(byte_data), 'h33);
        send_char("4");
        idle(10);
        check("clr_then_digit0", int'(digit0), 4);

        // random traffic
        for (int k = 0; k < 20; k++) begin
            r  = int'($urandom_range(0, 99));
            ok = 1'b1;
            if (r < 50)      rb = 8'h30 + 8'($urandom_range(0, 9));
            else if (r < 62) rb = 8'h0D;
            else             rb = 8'($urandom_range(0, 255));
            if (r >= 85) ok = 1'b0;
            send_frame(rb, ok, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, FRAME_CYC - 1)) : -1, -1);
            gap = ok ? int'($urandom_range(0, 1) * $urandom_range(0, 60)) : int'($urandom_range(4, 60));
            idle(gap);
        end
        idle(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
